// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the JTAG TAP model: state encoding, IR width,
// opcode defaults, IDCODE default and the Capture-IR constant.
package jtag_tap_pkg;

    localparam int          TAP_IR_LEN     = 6;
    localparam logic [31:0] TAP_IDCODE_VAL = 32'h0362D093;

    localparam logic [TAP_IR_LEN-1:0] OP_USER1  = 6'h02;
    localparam logic [TAP_IR_LEN-1:0] OP_USER2  = 6'h03;
    localparam logic [TAP_IR_LEN-1:0] OP_USER3  = 6'h22;
    localparam logic [TAP_IR_LEN-1:0] OP_USER4  = 6'h23;
    localparam logic [TAP_IR_LEN-1:0] OP_IDCODE = 6'h09;
    localparam logic [TAP_IR_LEN-1:0] OP_BYPASS = 6'h3F;

    // The two LSBs 01 are what Shift-IR presents first, as 1149.1 requires.
    localparam logic [TAP_IR_LEN-1:0] IR_CAPTURE = 6'b000001;

    // Conventional 1149.1 debug encodings, so a state dump reads like a datasheet.
    typedef enum logic [3:0] {
        ST_EXIT2_DR   = 4'h0,
        ST_EXIT1_DR   = 4'h1,
        ST_SHIFT_DR   = 4'h2,
        ST_PAUSE_DR   = 4'h3,
        ST_SELECT_IR  = 4'h4,
        ST_UPDATE_DR  = 4'h5,
        ST_CAPTURE_DR = 4'h6,
        ST_SELECT_DR  = 4'h7,
        ST_EXIT2_IR   = 4'h8,
        ST_EXIT1_IR   = 4'h9,
        ST_SHIFT_IR   = 4'hA,
        ST_PAUSE_IR   = 4'hB,
        ST_RTI        = 4'hC,
        ST_UPDATE_IR  = 4'hD,
        ST_CAPTURE_IR = 4'hE,
        ST_TLR        = 4'hF
    } tap_state_e;

endpackage

// File: rtl/jtag_tap_if.sv
// JTAG pin side and BSCAN-style user-chain side of the TAP, plus debug taps.
interface jtag_tap_if #(
    parameter int IR_LEN = jtag_tap_pkg::TAP_IR_LEN
);
    import jtag_tap_pkg::*;

    logic              tms;
    logic              tdi;
    logic              tdo;
    logic              tdo_en;
    logic [3:0]        user_tdo;
    logic [3:0]        sel;
    logic              capture;
    logic              shift;
    logic              update;
    logic              tlr;
    logic              rti;
    logic              user_tdi;
    tap_state_e        dbg_state;
    logic [IR_LEN-1:0] dbg_ir;

    // Strobe protocol: capture/shift/update are level decodes of the TAP state,
    // one tck period each; user chain n acts on the rising edge where the strobe
    // AND sel[n-1] are high, and returns its serial bit on user_tdo[n-1].
    modport slave (
        input  tms, tdi, user_tdo,
        output tdo, tdo_en, sel, capture, shift, update, tlr, rti, user_tdi,
        output dbg_state, dbg_ir
    );

    modport master (
        output tms, tdi, user_tdo,
        input  tdo, tdo_en, sel, capture, shift, update, tlr, rti, user_tdi,
        input  dbg_state, dbg_ir
    );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP controller: state register, TMS next-state logic and
// one-hot style state decodes used by the IR/DR datapath.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tms,
    output tap_state_e o_state,
    output logic       o_enter_tlr,
    output logic       o_tlr,
    output logic       o_rti,
    output logic       o_capture_dr,
    output logic       o_shift_dr,
    output logic       o_update_dr,
    output logic       o_capture_ir,
    output logic       o_shift_ir,
    output logic       o_update_ir
);

    tap_state_e r_state;
    tap_state_e w_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_TLR;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_TLR:        w_next = i_tms ? ST_TLR       : ST_RTI;
            ST_RTI:        w_next = i_tms ? ST_SELECT_DR : ST_RTI;
            ST_SELECT_DR:  w_next = i_tms ? ST_SELECT_IR : ST_CAPTURE_DR;
            ST_CAPTURE_DR: w_next = i_tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_SHIFT_DR:   w_next = i_tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_EXIT1_DR:   w_next = i_tms ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:   w_next = i_tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:   w_next = i_tms ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR:  w_next = i_tms ? ST_SELECT_DR : ST_RTI;
            ST_SELECT_IR:  w_next = i_tms ? ST_TLR       : ST_CAPTURE_IR;
            ST_CAPTURE_IR: w_next = i_tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_SHIFT_IR:   w_next = i_tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_EXIT1_IR:   w_next = i_tms ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:   w_next = i_tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:   w_next = i_tms ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR:  w_next = i_tms ? ST_SELECT_DR : ST_RTI;
            default:       w_next = ST_TLR;
        endcase
    end

    // Reset overrides the decodes so strobes are quiet even before the first edge.
    assign o_state      = r_state;
    assign o_enter_tlr  = !i_rst && (w_next == ST_TLR);
    assign o_tlr        = i_rst || (r_state == ST_TLR);
    assign o_rti        = !i_rst && (r_state == ST_RTI);
    assign o_capture_dr = !i_rst && (r_state == ST_CAPTURE_DR);
    assign o_shift_dr   = !i_rst && (r_state == ST_SHIFT_DR);
    assign o_update_dr  = !i_rst && (r_state == ST_UPDATE_DR);
    assign o_capture_ir = !i_rst && (r_state == ST_CAPTURE_IR);
    assign o_shift_ir   = !i_rst && (r_state == ST_SHIFT_IR);
    assign o_update_ir  = !i_rst && (r_state == ST_UPDATE_IR);

endmodule

// File: rtl/jtag_tap_model.sv
// TAP top level: instruction register, BYPASS and IDCODE data registers,
// USER chain selects and the falling-edge tdo register.
module jtag_tap_model
    import jtag_tap_pkg::*;
#(
    parameter int                IR_LEN      = TAP_IR_LEN,
    parameter logic [31:0]       IDCODE_VAL  = TAP_IDCODE_VAL,
    parameter logic [IR_LEN-1:0] USER1_CODE  = OP_USER1,
    parameter logic [IR_LEN-1:0] USER2_CODE  = OP_USER2,
    parameter logic [IR_LEN-1:0] USER3_CODE  = OP_USER3,
    parameter logic [IR_LEN-1:0] USER4_CODE  = OP_USER4,
    parameter logic [IR_LEN-1:0] IDCODE_CODE = OP_IDCODE,
    parameter logic [IR_LEN-1:0] BYPASS_CODE = OP_BYPASS
) (
    input logic        tck,
    input logic        rst,
    jtag_tap_if.slave  jtag
);

    tap_state_e        w_state;
    logic              w_enter_tlr;
    logic              w_tlr;
    logic              w_rti;
    logic              w_capture_dr;
    logic              w_shift_dr;
    logic              w_update_dr;
    logic              w_capture_ir;
    logic              w_shift_ir;
    logic              w_update_ir;
    logic [3:0]        w_sel;
    logic              w_is_idcode;
    logic              w_bypass_sel;
    logic              w_dr_tdo;

    logic [IR_LEN-1:0] r_ir;
    logic [IR_LEN-1:0] r_ir_sh;
    logic              r_bypass;
    logic [31:0]       r_idcode;
    logic              r_tdo;
    logic              r_tdo_en;

    jtag_tap_fsm u_fsm (
        .i_clk        (tck),
        .i_rst        (rst),
        .i_tms        (jtag.tms),
        .o_state      (w_state),
        .o_enter_tlr  (w_enter_tlr),
        .o_tlr        (w_tlr),
        .o_rti        (w_rti),
        .o_capture_dr (w_capture_dr),
        .o_shift_dr   (w_shift_dr),
        .o_update_dr  (w_update_dr),
        .o_capture_ir (w_capture_ir),
        .o_shift_ir   (w_shift_ir),
        .o_update_ir  (w_update_ir)
    );

    // Loading IDCODE on the edge that enters TLR keeps sel low for all of TLR.
    always_ff @(posedge tck) begin
        if (rst) begin
            r_ir     <= IDCODE_CODE;
            r_ir_sh  <= IR_CAPTURE;
            r_bypass <= 1'b0;
            r_idcode <= '0;
        end else begin
            if (w_capture_ir)    r_ir_sh <= IR_CAPTURE;
            else if (w_shift_ir) r_ir_sh <= {jtag.tdi, r_ir_sh[IR_LEN-1:1]};

            if (w_enter_tlr)      r_ir <= IDCODE_CODE;
            else if (w_update_ir) r_ir <= r_ir_sh;

            if (w_capture_dr) begin
                r_bypass <= 1'b0;
                r_idcode <= IDCODE_VAL;
            end else if (w_shift_dr) begin
                r_bypass <= jtag.tdi;
                r_idcode <= {jtag.tdi, r_idcode[31:1]};
            end
        end
    end

    always_comb begin
        w_sel = '0;
        if (!w_tlr) begin
            w_sel[0] = (r_ir == USER1_CODE);
            w_sel[1] = (r_ir == USER2_CODE);
            w_sel[2] = (r_ir == USER3_CODE);
            w_sel[3] = (r_ir == USER4_CODE);
        end
    end

    // Any opcode that is neither IDCODE nor a USER chain behaves as BYPASS.
    assign w_is_idcode  = (r_ir == IDCODE_CODE);
    assign w_bypass_sel = (r_ir == BYPASS_CODE) || !(w_is_idcode || (|w_sel));

    always_comb begin
        w_dr_tdo = r_bypass;
        if (w_bypass_sel)     w_dr_tdo = r_bypass;
        else if (w_is_idcode) w_dr_tdo = r_idcode[0];
        else                  w_dr_tdo = |(w_sel & jtag.user_tdo);
    end

    always_ff @(negedge tck) begin
        if (rst) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else if (w_shift_ir) begin
            r_tdo    <= r_ir_sh[0];
            r_tdo_en <= 1'b1;
        end else if (w_shift_dr) begin
            r_tdo    <= w_dr_tdo;
            r_tdo_en <= 1'b1;
        end else begin
            r_tdo_en <= 1'b0;
        end
    end

    assign jtag.tdo       = r_tdo;
    assign jtag.tdo_en    = r_tdo_en;
    assign jtag.sel       = w_sel;
    assign jtag.capture   = w_capture_dr;
    assign jtag.shift     = w_shift_dr;
    assign jtag.update    = w_update_dr;
    assign jtag.tlr       = w_tlr;
    assign jtag.rti       = w_rti;
    assign jtag.user_tdi  = jtag.tdi;
    assign jtag.dbg_state = w_state;
    assign jtag.dbg_ir    = r_ir;

endmodule

// File: tb/tb_jtag_tap_model.sv
// Bench for jtag_tap_model: queue-based TAP reference model, per-cycle compare,
// a 32-bit USER4 fabric register, directed scans and a randomized phase.
module tb_jtag_tap_model;

    logic tck = 1'b0;
    logic rst = 1'b1;

    jtag_tap_if jtag ();

    jtag_tap_model dut (
        .tck  (tck),
        .rst  (rst),
        .jtag (jtag)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Fabric user logic on USER4; the other user_tdo bits are random noise.
    logic [31:0] r_ureg  = '0;
    logic [31:0] r_uhold = '0;
    logic [2:0]  r_urand = '0;

    always @(posedge tck) begin
        r_urand <= 3'($urandom);
        if (jtag.sel[3] && jtag.capture) r_ureg <= r_uhold;
        if (jtag.sel[3] && jtag.shift)   r_ureg <= {jtag.tdi, r_ureg[31:1]};
        if (jtag.sel[3] && jtag.update)  r_uhold <= r_ureg;
    end
    assign jtag.user_tdo = {r_ureg[0], r_urand};

    // Reference model: states are plain table indices, registers are bit queues.
    localparam int S_TLR = 0, S_RTI = 1, S_CDR = 3, S_SDR = 4, S_UDR = 8;
    localparam int S_CIR = 10, S_SIR = 11, S_UIR = 15;
    int nxt_tbl [16][2] = '{
        '{1, 0},   '{1, 2},   '{3, 9},   '{4, 5},
        '{4, 5},   '{6, 8},   '{6, 7},   '{4, 8},
        '{1, 2},   '{10, 0},  '{11, 12}, '{11, 12},
        '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}
    };

    int          ms   = S_TLR;
    logic [5:0]  mir  = 6'h09;
    bit          irq[$];
    bit          drq[$];
    logic        mtdo = 1'b0;
    logic        men  = 1'b0;
    logic [31:0] idv  = 32'h0362D093;

    function automatic logic [3:0] user_onehot(input logic [5:0] ir);
        case (ir)
            6'h02:   return 4'b0001;
            6'h03:   return 4'b0010;
            6'h22:   return 4'b0100;
            6'h23:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    always @(posedge tck) begin
        if (rst) begin
            ms  = S_TLR;
            mir = 6'h09;
            irq.delete();
            drq.delete();
        end else begin
            case (ms)
                S_CIR: begin
                    irq.delete();
                    for (int i = 0; i < 6; i++) irq.push_back(i == 0);
                end
                S_SIR: begin
                    irq.push_back(jtag.tdi);
                    void'(irq.pop_front());
                end
                S_UIR: for (int i = 0; i < 6; i++) mir[i] = irq[i];
                S_CDR: begin
                    drq.delete();
                    if (user_onehot(mir) == 4'b0) begin
                        if (mir == 6'h09) for (int i = 0; i < 32; i++) drq.push_back(idv[i]);
                        else drq.push_back(1'b0);
                    end
                end
                S_SDR: if (user_onehot(mir) == 4'b0) begin
                    drq.push_back(jtag.tdi);
                    void'(drq.pop_front());
                end
                default: ;
            endcase
            ms = nxt_tbl[ms][int'(jtag.tms)];
            if (ms == S_TLR) mir = 6'h09;
        end
    end

    always @(negedge tck) begin
        if (rst) begin
            mtdo = 1'b0;
            men  = 1'b0;
        end else if (ms == S_SIR) begin
            mtdo = irq[0];
            men  = 1'b1;
        end else if (ms == S_SDR) begin
            if (user_onehot(mir) != 4'b0) mtdo = |(user_onehot(mir) & jtag.user_tdo);
            else if (drq.size() > 0)      mtdo = drq[0];
            men = 1'b1;
        end else begin
            men = 1'b0;
        end
    end

    // Per-cycle compare, sampled 1 time unit after each falling edge.
    logic chk_en  = 1'b0;
    int   cnt_cap = 0;
    int   cnt_sh  = 0;
    int   cnt_upd = 0;

    initial begin
        forever begin
            @(negedge tck);
            #1;
            if (chk_en) begin
                check("strobes",
                      {jtag.tlr, jtag.rti, jtag.capture, jtag.shift, jtag.update, jtag.user_tdi},
                      {rst || ms == S_TLR, !rst && ms == S_RTI, !rst && ms == S_CDR,
                       !rst && ms == S_SDR, !rst && ms == S_UDR, jtag.tdi});
                check("sel", jtag.sel, (rst || ms == S_TLR) ? 4'b0 : user_onehot(mir));
                check("ir", jtag.dbg_ir, mir);
                check("tdo", {jtag.tdo_en, jtag.tdo}, {men, mtdo});
                cnt_cap += int'(jtag.capture);
                cnt_sh  += int'(jtag.shift);
                cnt_upd += int'(jtag.update);
            end
        end
    end

    // Driver tasks: inputs change 2 units after the falling edge.
    task automatic tick(input logic t, input logic d, output logic o);
        @(negedge tck);
        #2;
        o        = jtag.tdo;
        jtag.tms = t;
        jtag.tdi = d;
    endtask

    task automatic step(input logic t);
        logic o;
        tick(t, 1'($urandom_range(0, 1)), o);
    endtask

    task automatic sync();
        @(posedge tck);
        #1;
    endtask

    task automatic go_rti();
        repeat (5) step(1'b1);
        step(1'b0);
    endtask

    task automatic scan_ir(input logic [5:0] v, output logic [5:0] out);
        out = '0;
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < 6; i++) tick(i == 5, v[i], out[i]);
        step(1'b1); step(1'b0);
    endtask

    task automatic scan_dr(input int n, input logic [63:0] v, output logic [63:0] out);
        out = '0;
        step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < n; i++) tick(i == n - 1, v[i], out[i]);
        step(1'b1); step(1'b0);
    endtask

    task automatic pulse_rst();
        @(negedge tck); #2; rst = 1'b1;
        @(negedge tck); #2; rst = 1'b0;
    endtask

    logic [5:0]  ir_out;
    logic [63:0] dr_out;
    int          c_cap, c_sh, c_upd;
    logic [5:0]  codes [8] = '{6'h02, 6'h03, 6'h22, 6'h23, 6'h09, 6'h3F, 6'h00, 6'h00};

    initial begin
        jtag.tms = 1'b1;
        jtag.tdi = 1'b0;
        @(negedge tck); #2;
        check("rst_tlr", jtag.tlr, 1'b1);
        check("rst_ir", jtag.dbg_ir, 6'h09);
        check("rst_sel", jtag.sel, 4'b0);
        check("rst_tdo", {jtag.tdo_en, jtag.tdo}, 2'b00);
        chk_en = 1'b1;
        rst    = 1'b0;

        // Into Shift-DR, then five TMS ones must land in TLR.
        step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        repeat (5) step(1'b1);
        sync();
        check("tms5_tlr", jtag.tlr, 1'b1);
        check("tms5_ir", jtag.dbg_ir, 6'h09);
        check("tms5_sel", jtag.sel, 4'b0);

        step(1'b0);
        scan_dr(32, 64'h0, dr_out);
        check("idcode_scan", dr_out[31:0], 32'h0362D093);

        scan_ir(6'b100011, ir_out);
        sync();
        check("ir_capture_stream", ir_out, 6'b000001);
        check("user4_sel", jtag.sel, 4'b1000);

        c_cap = cnt_cap; c_sh = cnt_sh; c_upd = cnt_upd;
        scan_dr(63, {1'b0, 32'hFF55AA00, 31'b0}, dr_out);
        sync();
        check("user4_reg", r_uhold, 32'hFF55AA00);
        check("user4_shifts", cnt_sh - c_sh, 63);
        check("user4_capture", cnt_cap - c_cap, 1);
        check("user4_update", cnt_upd - c_upd, 1);

        scan_ir(6'h3F, ir_out);
        scan_dr(4, 64'b1101, dr_out);
        check("bypass_stream", dr_out[3:0], 4'b1010);

        // Reset during Shift-IR after three bits.
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        step(1'b0); step(1'b0); step(1'b0);
        c_upd = cnt_upd;
        pulse_rst();
        check("midrst_tlr", jtag.tlr, 1'b1);
        check("midrst_ir", jtag.dbg_ir, 6'h09);
        check("midrst_sel", jtag.sel, 4'b0);
        check("midrst_noupd", cnt_upd - c_upd, 0);
        step(1'b0);

        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 3))
                0: begin
                    repeat ($urandom_range(1, 20)) begin
                        if ($urandom_range(0, 15) == 0) pulse_rst();
                        else step(1'($urandom_range(0, 1)));
                    end
                    go_rti();
                end
                1: begin
                    codes[6] = 6'($urandom);
                    scan_ir(codes[$urandom_range(0, 7)], ir_out);
                end
                2: scan_dr($urandom_range(1, 64), {$urandom, $urandom}, dr_out);
                default: begin
                    pulse_rst();
                    step(1'b0);
                end
            endcase
        end

        sync();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
